grid_image_locator: RTL

Parametrised successor of the product-grid image locator. Maps the scan position (CounterX/CounterY) onto a NUM_COLS x NUM_ROWS grid of equal product tiles and emits a tile ID, a tile-hit flag, a ROM address and a highlight-indicator flag. Output is a fixed 2-cycle pipeline, aligned to the pixel strobe. The highlight mask is latched per frame to avoid tearing. Sits between the HVSync counter block and the image ROM / pixel mux.

---
 rtl/grid_image_locator.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/grid_image_locator.sv
// grid_image_locator
// Maps the scan position onto a NUM_COLS x NUM_ROWS grid of product tiles.
// For each pixel it emits the tile ID, a tile-hit flag, the image ROM address
// and a highlight-indicator flag.
// The result leaves a fixed two-stage pipeline, aligned with the pixel strobe.
// Optional macro BLINK_EN: when defined, the highlight indicator blinks with a
// half-period of BLINK_FRAMES frames. When undefined, the indicator is steady.
//
// Handshake: PixelEn qualifies CounterX/CounterY in the same cycle. OutValid
// qualifies ImageID/isImage/ROM_Addr/inHighlightedArea exactly two CLK later.
// There is no backpressure, so every accepted pixel produces one output beat.
module grid_image_locator #(
    parameter int CNTR_WIDTH_H       = 11,
    parameter int CNTR_WIDTH_V       = 10,
    parameter int ROM_ADDR_BUS_WIDTH = 17,
    parameter int NUM_COLS           = 4,
    parameter int NUM_ROWS           = 3,
    parameter int TILE_W             = 100,
    parameter int TILE_H             = 100,
    parameter int PITCH_X            = 128,
    parameter int PITCH_Y            = 128,
    parameter int ORIGIN_X           = 308,
    parameter int ORIGIN_Y           = 20,
    parameter int IND_SIZE           = 10,
    parameter int BLINK_FRAMES       = 30,
    localparam int NUM_TILES         = NUM_COLS * NUM_ROWS,
    localparam int ID_W              = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [CNTR_WIDTH_H-1:0]       CounterX,
    input  logic [CNTR_WIDTH_V-1:0]       CounterY,
    input  logic                          PixelEn,
    input  logic                          FrameStart,
    input  logic [NUM_TILES-1:0]          HighlightedProductList,
    output logic [ID_W-1:0]               ImageID,
    output logic                          isImage,
    output logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_Addr,
    output logic                          inHighlightedArea,
    output logic                          OutValid
);

    localparam int AW = ROM_ADDR_BUS_WIDTH;

    // ------------------------------------------------------------------
    // Highlight mask and blink phase
    // ------------------------------------------------------------------
    logic [NUM_TILES-1:0] mask;
    logic                 blink_phase;

    // Mask is captured only at frame start so a mid-frame change cannot tear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mask <= '0;
        end else if (FrameStart) begin
            mask <= HighlightedProductList;
        end
    end

`ifdef BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FC_W-1:0] frame_cnt;

    // Frame counter wraps after BLINK_FRAMES frame starts and flips the phase.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (FrameStart) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    // Steady indicator: the phase is constant. BLINK_FRAMES is kept only so
    // both builds share one parameter list.
    assign blink_phase = (BLINK_FRAMES > 0) || 1'b1;
`endif

    // ------------------------------------------------------------------
    // Stage 1 combinational: per-column / per-row window comparators
    // ------------------------------------------------------------------
    logic [NUM_COLS-1:0]     col_hit;
    logic [NUM_ROWS-1:0]     row_hit;
    logic [CNTR_WIDTH_H-1:0] col_off [NUM_COLS];
    logic [CNTR_WIDTH_V-1:0] row_off [NUM_ROWS];
    logic [CNTR_WIDTH_H-1:0] lx_d;
    logic [CNTR_WIDTH_V-1:0] ly_d;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        localparam int unsigned LO = ORIGIN_X + c * PITCH_X;
        assign col_hit[c] = (32'(CounterX) >= LO) && (32'(CounterX) < LO + TILE_W);
        assign col_off[c] = col_hit[c] ? (CounterX - CNTR_WIDTH_H'(LO)) : '0;
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        localparam int unsigned LO = ORIGIN_Y + r * PITCH_Y;
        assign row_hit[r] = (32'(CounterY) >= LO) && (32'(CounterY) < LO + TILE_H);
        assign row_off[r] = row_hit[r] ? (CounterY - CNTR_WIDTH_V'(LO)) : '0;
    end

    // Windows never overlap (pitch >= tile size), so OR-merging offsets is a mux.
    always_comb begin
        lx_d = '0;
        ly_d = '0;
        for (int c = 0; c < NUM_COLS; c++) lx_d = lx_d | col_off[c];
        for (int r = 0; r < NUM_ROWS; r++) ly_d = ly_d | row_off[r];
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic                    s1_valid;
    logic                    s1_hit;
    logic [NUM_COLS-1:0]     s1_col;
    logic [NUM_ROWS-1:0]     s1_row;
    logic [CNTR_WIDTH_H-1:0] s1_lx;
    logic [CNTR_WIDTH_V-1:0] s1_ly;
    logic [NUM_TILES-1:0]    s1_mask;
    logic                    s1_blink;

    // Capture the pixel. Mask and phase are snapshotted here, so a pixel
    // coinciding with FrameStart still sees the previous frame's mask.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_lx    <= '0;
            s1_ly    <= '0;
            s1_mask  <= '0;
            s1_blink <= 1'b1;
        end else begin
            s1_valid <= PixelEn;
            s1_hit   <= PixelEn & (|col_hit) & (|row_hit);
            if (PixelEn) begin
                s1_col   <= col_hit;
                s1_row   <= row_hit;
                s1_lx    <= lx_d;
                s1_ly    <= ly_d;
                s1_mask  <= mask;
                s1_blink <= blink_phase;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: tile index, ROM address, indicator
    // ------------------------------------------------------------------
    logic [ID_W-1:0] col_idx;
    logic [ID_W-1:0] row_idx;
    logic [ID_W-1:0] id_d;
    logic [AW-1:0]   addr_d;
    logic            mask_sel;
    logic            in_ind;

    // One-hot to binary, tile index and highlight bit of the hit tile.
    always_comb begin
        col_idx  = '0;
        row_idx  = '0;
        mask_sel = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (s1_col[c]) col_idx = col_idx | ID_W'(c);
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (s1_row[r]) row_idx = row_idx | ID_W'(r);
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                mask_sel = mask_sel | (s1_row[r] & s1_col[c] & s1_mask[r * NUM_COLS + c]);
            end
        end
        id_d   = row_idx * ID_W'(NUM_COLS) + col_idx;
        addr_d = AW'(id_d) * AW'(TILE_W * TILE_H) + AW'(s1_ly) * AW'(TILE_W) + AW'(s1_lx);
        in_ind = (32'(s1_lx) < IND_SIZE) && (32'(s1_ly) < IND_SIZE);
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (outputs); misses force every data output to zero
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OutValid          <= 1'b0;
            ImageID           <= '0;
            isImage           <= 1'b0;
            ROM_Addr          <= '0;
            inHighlightedArea <= 1'b0;
        end else begin
            OutValid <= s1_valid;
            if (s1_hit) begin
                ImageID           <= id_d;
                isImage           <= 1'b1;
                ROM_Addr          <= addr_d;
                inHighlightedArea <= in_ind & mask_sel & s1_blink;
            end else begin
                ImageID           <= '0;
                isImage           <= 1'b0;
                ROM_Addr          <= '0;
                inHighlightedArea <= 1'b0;
            end
        end
    end

endmodule
